// File: rtl/ara_inval_queue_pkg.sv
// Shared helpers for the invalidation queue.
// Holds only elaboration-time helpers; no types are exported to the wider codebase.
package ara_inval_queue_pkg;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ara_inval_queue.sv
// ara_inval_queue: buffers and coalesces L1 D-cache line invalidations between the AXI
// invalidation filter on Ara's memory port and CVA6's invalidation handshake.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   en_i           coherence enable; when low, accepted requests are discarded
//   inval_addr_i   invalidation address from the filter
//   inval_valid_i  upstream valid
//   inval_ready_o  upstream ready (state and en_i only)
//   inval_addr_o   line-aligned address to the core (head entry)
//   inval_valid_o  downstream valid (queue not empty)
//   inval_ready_i  downstream ready from the core
//   coalesced_o    pulse when an accepted request is dropped as a duplicate
//   count_o        current occupancy
module ara_inval_queue
  import ara_inval_queue_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [AddrWidth-1:0]     inval_addr_i,
  input  logic                     inval_valid_i,
  output logic                     inval_ready_o,
  output logic [AddrWidth-1:0]     inval_addr_o,
  output logic                     inval_valid_o,
  input  logic                     inval_ready_i,
  output logic                     coalesced_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam int unsigned OffWidth = $clog2(L1LineWidth);
  localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << OffWidth) - AddrWidth'(1));

  if (!is_pow2(Depth) || Depth < 2) begin : gen_bad_depth
    $error("ara_inval_queue: Depth must be a power of two and at least 2");
  end
  if (!is_pow2(L1LineWidth) || L1LineWidth < 2) begin : gen_bad_line
    $error("ara_inval_queue: L1LineWidth must be a power of two and at least 2");
  end

  logic [AddrWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  head_q, tail_q, tail_prev;
  logic [CntWidth-1:0]  count_q;

  logic [AddrWidth-1:0] line;
  logic full, empty, push_req, pop, hit, enq;

  always_comb begin
    line          = inval_addr_i & LineMask;
    full          = (count_q == CntWidth'(Depth));
    empty         = (count_q == '0);
    tail_prev     = tail_q - PtrWidth'(1);
    inval_ready_o = !full || !en_i;
    push_req      = inval_valid_i && inval_ready_o;
    pop           = !empty && inval_ready_i;
    // Only the newest entry is a coalescing target, and never one that is leaving
    // this cycle: a line already handed to the core must be invalidated again.
    hit           = push_req && en_i && !empty && (line == mem_q[tail_prev]) &&
                    !(pop && (count_q == CntWidth'(1)));
    enq           = push_req && en_i && !hit;
    coalesced_o   = hit;
    inval_valid_o = !empty;
    inval_addr_o  = mem_q[head_q];
    count_o       = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem_q[tail_q] <= line;
        tail_q        <= tail_q + PtrWidth'(1);
      end
      if (pop) begin
        head_q <= head_q + PtrWidth'(1);
      end
      if (enq && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !enq) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_ara_inval_queue.sv
// Self-checking bench for ara_inval_queue: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model of the queue's rules.
module tb_ara_inval_queue;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [63:0] inval_addr_i;
  logic        inval_valid_i;
  logic        inval_ready_o;
  logic [63:0] inval_addr_o;
  logic        inval_valid_o;
  logic        inval_ready_i;
  logic        coalesced_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] mq[$];  // pending aligned lines, oldest first

  ara_inval_queue #(
    .AddrWidth  (64),
    .L1LineWidth(16),
    .Depth      (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .inval_addr_i (inval_addr_i),
    .inval_valid_i(inval_valid_i),
    .inval_ready_o(inval_ready_o),
    .inval_addr_o (inval_addr_o),
    .inval_valid_o(inval_valid_o),
    .inval_ready_i(inval_ready_i),
    .coalesced_o  (coalesced_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance model at the edge.
  task automatic step(input logic v, input logic [63:0] a, input logic e, input logic r);
    logic        exp_ready, push, pop, coal;
    logic [63:0] line;
    inval_valid_i = v;
    inval_addr_i  = a;
    en_i          = e;
    inval_ready_i = r;
    @(negedge clk);
    line      = a & ~64'hF;
    exp_ready = (mq.size() < Depth) || !e;
    push      = v && exp_ready;
    pop       = (mq.size() > 0) && r;
    coal      = push && e && (mq.size() > 0) && (line == mq[$]) &&
                !(pop && mq.size() == 1);
    check("ready", 64'(inval_ready_o), 64'(exp_ready));
    check("valid", 64'(inval_valid_o), 64'(mq.size() > 0));
    check("count", 64'(count_o), 64'(mq.size()));
    check("coalesced", 64'(coalesced_o), 64'(coal));
    if (mq.size() > 0) check("addr", inval_addr_o, mq[0]);
    if (pop) void'(mq.pop_front());
    if (push && e && !coal) mq.push_back(line);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    inval_valid_i = 1'b0;
    inval_ready_i = 1'b0;
    en_i          = 1'b1;
    inval_addr_i  = '0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    mq.delete();
    @(negedge clk);
    check("rst_valid", 64'(inval_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_addr", inval_addr_o, 64'(0));
    check("rst_ready", 64'(inval_ready_o), 64'(1));
    check("rst_coalesced", 64'(coalesced_o), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < Depth + 2; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("drained", 64'(mq.size()), 64'(0));
  endtask

  initial begin
    rst_i = 1'b1;
    inval_valid_i = 1'b0;
    inval_ready_i = 1'b0;
    en_i = 1'b1;
    inval_addr_i = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single request, alignment and pop.
    step(1'b1, 64'h1004, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back duplicates coalesce.
    step(1'b1, 64'h2000, 1'b1, 1'b0);
    step(1'b1, 64'h2008, 1'b1, 1'b0);
    step(1'b1, 64'h200F, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Only the newest entry is compared.
    step(1'b1, 64'h3000, 1'b1, 1'b0);
    step(1'b1, 64'h4000, 1'b1, 1'b0);
    step(1'b1, 64'h3000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Leaving entry is not a coalesce target.
    step(1'b1, 64'h5000, 1'b1, 1'b0);
    step(1'b1, 64'h5000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill, stall at full, then FIFO drain.
    step(1'b1, 64'h7000, 1'b1, 1'b0);
    step(1'b1, 64'h7100, 1'b1, 1'b0);
    step(1'b1, 64'h7200, 1'b1, 1'b0);
    step(1'b1, 64'h7300, 1'b1, 1'b0);
    step(1'b1, 64'h7400, 1'b1, 1'b0);
    step(1'b1, 64'h7400, 1'b1, 1'b1);
    step(1'b1, 64'h7400, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Disabled requests are discarded, stored entries drain, reset mid-drain.
    step(1'b1, 64'h8000, 1'b1, 1'b0);
    step(1'b1, 64'h8100, 1'b1, 1'b0);
    step(1'b1, 64'h6000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    do_reset();

    // Random traffic over a small line pool to provoke coalescing and full stalls.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] a;
      a = 64'h9000 + 64'(($urandom_range(0, 3)) << 4) + 64'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
